// File: rtl/aprop.sv
// aprop: one-cog Propeller-style core, 4 clocks per instruction, 512x32 cog RAM.
// Define APROP_PORTB_EN to add port_b with INB/OUTB/DIRB at 1F3/1F5/1F7.
module aprop #(
  parameter logic [8:0] PC_RESET = 9'h000
) (
  input  logic        clk_in,
  input  logic        reset_in,
  inout  wire  [31:0] port_a
`ifdef APROP_PORTB_EN
  ,
  inout  wire  [31:0] port_b
`endif
);

  typedef enum logic [1:0] {S0, S1, S2, S3} ph_t;

  ph_t         ph, ph_nx;
  logic [31:0] ram [512];
  logic [31:0] ir, sv, dv, cnt;
  logic [31:0] outa, dira;
  logic [8:0]  pc, pc_inc, pc_nx;
  logic        zf, cf;
`ifdef APROP_PORTB_EN
  logic [31:0] outb, dirb;
`endif

  logic [5:0]  op;
  logic        wz, wc, wr, imm;
  logic [3:0]  cnd;
  logic [8:0]  da, sa, raddr;
  logic [31:0] rdata, res;
  logic        cout, wen, flg, stall, run, sfr_w;

  assign op  = ir[31:26];
  assign wz  = ir[25];
  assign wc  = ir[24];
  assign wr  = ir[23];
  assign imm = ir[22];
  assign cnd = ir[21:18];
  assign da  = ir[17:9];
  assign sa  = ir[8:0];

  // operand read port: S address in S1, D address otherwise
  always_comb begin
    raddr = (ph == S1) ? sa : da;
    rdata = ram[raddr];
    unique case (1'b1)
      raddr == 9'h1F1: rdata = cnt;
      raddr == 9'h1F2: rdata = port_a;
      raddr == 9'h1F4: rdata = outa;
      raddr == 9'h1F6: rdata = dira;
`ifdef APROP_PORTB_EN
      raddr == 9'h1F3: rdata = port_b;
      raddr == 9'h1F5: rdata = outb;
      raddr == 9'h1F7: rdata = dirb;
`endif
      default: ;
    endcase
  end

  // phase register
  always_ff @(posedge clk_in) begin
    if (!reset_in) ph <= S0;
    else           ph <= ph_nx;
  end

  // phase sequencing; WAITCNT holds S3
  always_comb begin
    ph_nx = S0;
    unique case (ph)
      S0: ph_nx = S1;
      S1: ph_nx = S2;
      S2: ph_nx = S3;
      S3: ph_nx = stall ? S3 : S0;
    endcase
  end

  // execute stage: result, flags, writeback and next PC
  always_comb begin
    res    = 32'h0;
    cout   = cf;
    wen    = 1'b0;
    flg    = 1'b0;
    stall  = 1'b0;
    pc_inc = pc + 9'd1;
    pc_nx  = pc_inc;
    run    = cnd[{cf, zf}];
    if (ph == S3 && run) begin
      flg = 1'b1;
      case (op)
        6'h00: begin res = sv; cout = ^sv; wen = wr; end
        6'h01: begin {cout, res} = {1'b0, dv} + {1'b0, sv}; wen = wr; end
        6'h02: begin {cout, res} = {1'b0, dv} - {1'b0, sv}; wen = wr; end
        6'h03: begin res = dv & sv; cout = ^(dv & sv); wen = wr; end
        6'h04: begin res = dv | sv; cout = ^(dv | sv); wen = wr; end
        6'h05: begin res = dv ^ sv; cout = ^(dv ^ sv); wen = wr; end
        6'h06: begin res = dv << sv[4:0]; cout = dv[31]; wen = wr; end
        6'h07: begin res = dv >> sv[4:0]; cout = dv[0]; wen = wr; end
        6'h08: begin
          res   = {dv[31:9], pc_inc};
          wen   = wr;
          flg   = 1'b0;
          pc_nx = sv[8:0];
        end
        6'h09: begin
          res   = dv - 32'd1;
          cout  = (dv == 32'h0);
          wen   = 1'b1;
          pc_nx = (dv != 32'd1) ? sv[8:0] : pc_inc;
        end
        6'h0A: begin {cout, res} = {1'b0, dv} - {1'b0, sv}; end
        6'h0B: begin
          if (cnt != dv) begin
            stall = 1'b1;
            flg   = 1'b0;
          end else begin
            {cout, res} = {1'b0, dv} + {1'b0, sv};
            wen = 1'b1;
          end
        end
        default: flg = 1'b0;
      endcase
    end
  end

  // writes to port registers bypass the RAM
  always_comb begin
    sfr_w = (da == 9'h1F4) || (da == 9'h1F6);
`ifdef APROP_PORTB_EN
    sfr_w = sfr_w || (da == 9'h1F5) || (da == 9'h1F7);
`endif
  end

  // free-running system counter
  always_ff @(posedge clk_in) begin
    if (!reset_in) cnt <= 32'h0;
    else           cnt <= cnt + 32'd1;
  end

  // cog RAM writeback; contents survive reset
  always_ff @(posedge clk_in) begin
    if (reset_in && wen && !sfr_w) ram[da] <= res;
  end

  // fetch, operand latch and architectural state update
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      pc   <= PC_RESET;
      ir   <= 32'h0;
      sv   <= 32'h0;
      dv   <= 32'h0;
      zf   <= 1'b0;
      cf   <= 1'b0;
      outa <= 32'h0;
      dira <= 32'h0;
`ifdef APROP_PORTB_EN
      outb <= 32'h0;
      dirb <= 32'h0;
`endif
    end else begin
      unique case (ph)
        S0: ir <= ram[pc];
        S1: sv <= imm ? {23'h0, sa} : rdata;
        S2: dv <= rdata;
        S3: if (!stall) begin
          pc <= pc_nx;
          if (flg && wz) zf <= (res == 32'h0);
          if (flg && wc) cf <= cout;
          if (wen && da == 9'h1F4) outa <= res;
          if (wen && da == 9'h1F6) dira <= res;
`ifdef APROP_PORTB_EN
          if (wen && da == 9'h1F5) outb <= res;
          if (wen && da == 9'h1F7) dirb <= res;
`endif
        end
      endcase
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_pa
    assign port_a[i] = dira[i] ? outa[i] : 1'bz;
  end
`ifdef APROP_PORTB_EN
  for (genvar i = 0; i < 32; i++) begin : g_pb
    assign port_b[i] = dirb[i] ? outb[i] : 1'bz;
  end
`endif

endmodule

// File: tb/tb_aprop.sv
// tb_aprop: instruction-level reference model plus timed checks
// for reset, port drive, DJNZ/JMPRET and WAITCNT.
module tb_aprop;

  logic       clk = 1'b0;
  logic       rst_n;
  wire [31:0] pa;

  aprop dut (
    .clk_in  (clk),
    .reset_in(rst_n),
    .port_a  (pa)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_ram [512];
  logic [8:0]  m_pc;
  logic        m_z, m_c;
  logic [31:0] m_outa, m_dira;

  localparam logic [8:0] R  = 9'h100;
  localparam logic [8:0] Q  = 9'h101;
  localparam logic [8:0] OA = 9'h1F4;
  localparam logic [8:0] DA = 9'h1F6;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input bit wz,
      input bit wc, input bit wr, input bit im, input logic [3:0] cd,
      input logic [8:0] d, input logic [8:0] s);
    logic [5:0] o;
    o = op[5:0];
    return {o, wz, wc, wr, im, cd, d, s};
  endfunction

  function automatic logic [31:0] m_rd(input logic [8:0] a);
    if (a == OA) return m_outa;
    if (a == DA) return m_dira;
    return m_ram[a];
  endfunction

  function automatic logic [31:0] dut_rd(input logic [8:0] a);
    if (a == OA) return dut.outa;
    if (a == DA) return dut.dira;
    return dut.ram[a];
  endfunction

  task automatic m_wr(input logic [8:0] a, input logic [31:0] v);
    if (a == OA)      m_outa = v;
    else if (a == DA) m_dira = v;
    else              m_ram[a] = v;
  endtask

  // one whole instruction, as the programmer sees it
  task automatic m_step();
    logic [31:0] w, s, d, r;
    logic [3:0]  cd;
    logic [8:0]  nxt, npc;
    bit          cy, wrt, fl;
    int          op;
    w   = m_ram[m_pc];
    op  = int'(w[31:26]);
    cd  = w[21:18];
    s   = w[22] ? {23'h0, w[8:0]} : m_rd(w[8:0]);
    d   = m_rd(w[17:9]);
    nxt = m_pc + 9'd1;
    npc = nxt;
    if (!cd[{m_c, m_z}]) begin
      m_pc = nxt;
      return;
    end
    wrt = w[23];
    fl  = 1;
    r   = 0;
    cy  = m_c;
    case (op)
      0:  begin r = s; cy = ^r; end
      1:  begin r = d + s; cy = ({32'h0, d} + {32'h0, s}) > 64'hFFFF_FFFF; end
      2:  begin r = d - s; cy = s > d; end
      3:  begin r = d & s; cy = ^r; end
      4:  begin r = d | s; cy = ^r; end
      5:  begin r = d ^ s; cy = ^r; end
      6:  begin r = d << s[4:0]; cy = d[31]; end
      7:  begin r = d >> s[4:0]; cy = d[0]; end
      8:  begin r = {d[31:9], nxt}; fl = 0; npc = s[8:0]; end
      9:  begin r = d - 1; wrt = 1; npc = (r != 0) ? s[8:0] : nxt; end
      10: begin r = d - s; cy = s > d; wrt = 0; end
      default: begin fl = 0; wrt = 0; end
    endcase
    if (fl && w[25]) m_z = (r == 0);
    if (fl && w[24]) m_c = cy;
    if (wrt) m_wr(w[17:9], r);
    m_pc = npc;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 512; i++) m_ram[i] = 32'h0;
  endtask

  task automatic boot();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 512; i++) dut.ram[i] = m_ram[i];
    m_pc = 0; m_z = 0; m_c = 0; m_outa = 0; m_dira = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step_chk(input string tag);
    logic [8:0] d;
    d = m_ram[m_pc][17:9];
    m_step();
    repeat (4) @(negedge clk);
    chk({tag, ".pc"}, 32'(dut.pc), 32'(m_pc));
    chk({tag, ".zc"}, {30'h0, dut.zf, dut.cf}, {30'h0, m_z, m_c});
    chk({tag, ".d"}, dut_rd(d), m_rd(d));
    chk({tag, ".port"}, pa & m_dira, m_outa & m_dira);
  endtask

  logic [8:0] ra, rs;
  int op, k, e1, e2;
  int ops [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 10, 12};

  function automatic logic [8:0] pick();
    int a;
    a = int'($urandom_range(9));
    if (a < 8) return R + 9'(a);
    return (a == 8) ? OA : DA;
  endfunction

  initial begin
    // reset hold, first fetch, DIRA/OUTA drive timing
    rst_n = 1'b0;
    m_clear();
    m_ram[0] = enc(0, 0, 0, 1, 1, 4'hF, DA, 9'h1FF);
    m_ram[1] = enc(0, 0, 0, 1, 1, 4'hF, OA, 9'h0A5);
    for (int i = 0; i < 512; i++) dut.ram[i] = m_ram[i];
    repeat (5) @(negedge clk);
    chk("rst.cnt", dut.cnt, 32'h0);
    chk("rst.pc", 32'(dut.pc), 32'h0);
    chk("rst.dira", dut.dira, 32'h0);
    chk("rst.outa", dut.outa, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("fetch0.ir", dut.ir, m_ram[0]);
    chk("fetch0.cnt", dut.cnt, 32'h1);
    repeat (6) @(negedge clk);
    chk("port7.dira", dut.dira, 32'h1FF);
    chk("port7.pa", pa & 32'h1FF, 32'h0);
    @(negedge clk);
    chk("port8.pa", pa & 32'h1FF, 32'h0A5);
    chk("port8.pc", 32'(dut.pc), 32'h2);

    // ADD wrap sets Z and C; if_nz skipped, if_z taken
    m_clear();
    m_ram[R] = 32'hFFFF_FFFF;
    m_ram[0] = enc(1, 1, 1, 1, 1, 4'hF, R, 9'h001);
    m_ram[1] = enc(0, 0, 0, 1, 1, 4'b0101, R, 9'h007);
    m_ram[2] = enc(0, 0, 0, 1, 1, 4'b1010, Q, 9'h009);
    boot();
    for (int i = 0; i < 3; i++) step_chk($sformatf("add[%0d]", i));
    chk("add.r", dut.ram[R], 32'h0);
    chk("add.q", dut.ram[Q], 32'h9);
    chk("add.zc", {30'h0, dut.zf, dut.cf}, 32'h3);

    // DJNZ loop of three, then fall through
    m_clear();
    m_ram[R] = 32'd3;
    m_ram[0] = enc(9, 0, 0, 0, 1, 4'hF, R, 9'h000);
    m_ram[1] = enc(0, 0, 0, 1, 1, 4'hF, Q, 9'h005);
    boot();
    for (int i = 0; i < 3; i++) step_chk($sformatf("djnz[%0d]", i));
    chk("djnz.r", dut.ram[R], 32'h0);
    chk("djnz.pc12", 32'(dut.pc), 32'h1);
    step_chk("djnz[3]");

    // JMPRET saves return address into D[8:0]
    m_clear();
    m_ram[R] = 32'hFFFF_FE00;
    m_ram[0] = enc(8, 0, 0, 1, 1, 4'hF, R, 9'h004);
    m_ram[4] = enc(0, 0, 0, 1, 1, 4'hF, Q, 9'h009);
    boot();
    step_chk("jmp[0]");
    chk("jmp.r", dut.ram[R], 32'hFFFF_FE01);
    step_chk("jmp[1]");

    // randomized straight-line programs against the model
    for (int p = 0; p < 4; p++) begin
      m_clear();
      for (int i = 0; i < 8; i++) m_ram[R + 9'(i)] = $urandom;
      for (int i = 0; i < 32; i++) begin
        op = ops[$urandom_range(9)];
        ra = pick();
        rs = pick();
        if ($urandom_range(1) == 1) rs = 9'($urandom);
        m_ram[i] = enc(op, 1'($urandom), (op != 0) && 1'($urandom),
                       1'($urandom), rs[8] ? 1'b0 : 1'($urandom),
                       ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF,
                       ra, rs);
      end
      boot();
      for (int i = 0; i < 32; i++) step_chk($sformatf("rnd%0d[%0d]", p, i));
    end

    // WAITCNT timing, then reset during a stall
    m_clear();
    m_ram[0] = enc(0, 0, 0, 1, 1, 4'hF, DA, 9'h003);
    m_ram[1] = enc(0, 0, 0, 1, 0, 4'hF, R, 9'h1F1);
    m_ram[2] = enc(1, 0, 0, 1, 1, 4'hF, R, 9'd50);
    m_ram[3] = enc(11, 0, 0, 1, 1, 4'hF, R, 9'd100);
    m_ram[4] = enc(0, 0, 0, 1, 1, 4'hF, OA, 9'h001);
    m_ram[5] = enc(11, 0, 0, 1, 1, 4'hF, R, 9'd100);
    m_ram[6] = enc(0, 0, 0, 1, 1, 4'hF, OA, 9'h003);
    m_ram[7] = enc(11, 0, 0, 1, 1, 4'hF, R, 9'd100);
    boot();
    k = 0; e1 = -1; e2 = -1;
    while (k < 400 && e2 < 0) begin
      @(negedge clk);
      k++;
      if (e1 < 0 && pa[0] === 1'b1) e1 = k;
      if (e2 < 0 && pa[1] === 1'b1) e2 = k;
    end
    // CNT read by instr 1 is 5; wait ends one clock after CNT==t,
    // and the following MOV OUTA lands four clocks later
    chk("wait.edge1", e1, 32'(5 + 50 + 1 + 4));
    chk("wait.edge2", e2, 32'(5 + 50 + 100 + 1 + 4));
    chk("wait.t", dut.ram[R], 32'(5 + 50 + 200));
    while (k < 190) begin
      @(negedge clk);
      k++;
    end
    chk("stall.pc", 32'(dut.pc), 32'h7);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("stallrst.outa", dut.outa, 32'h0);
    chk("stallrst.dira", dut.dira, 32'h0);
    chk("stallrst.pc", 32'(dut.pc), 32'h0);
    chk("stallrst.cnt", dut.cnt, 32'h0);
    chk("stallrst.ram", dut.ram[R], 32'(5 + 50 + 200));
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("restart.dira", dut.dira, 32'h3);
    chk("restart.pc", 32'(dut.pc), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
